// File: rtl/vm_pkg.sv
// Shared types and sizes for the page-table walker and its clock-hand replacer.
package vm_pkg;

  localparam int unsigned VPN_W      = 8;
  localparam int unsigned PPN_W      = 6;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned NUM_FRAMES = 64;
  localparam int unsigned NUM_PAGES  = 256;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic             referenced;
    logic [PPN_W-1:0] ppn;
  } pte_t;

  typedef struct packed {
    logic             used;
    logic [VPN_W-1:0] owner;
  } frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_UPDATE,
    S_SCAN_F,
    S_SCAN_P,
    S_ALLOC,
    S_RESP,
    S_CLEAR
  } walk_state_e;

endpackage

// File: rtl/page_table_walker_if.sv
// Walk request / response / eviction bus between the TLB side and the walker.
interface page_table_walker_if;
  import vm_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [VPN_W-1:0] req_vpn;
  logic             req_write;
  logic             resp_valid;
  logic             resp_ready;
  logic [PPN_W-1:0] resp_ppn;
  logic             resp_fault;
  logic             evict_valid;
  logic [VPN_W-1:0] evict_vpn;
  logic             evict_dirty;

  modport slave (
    input  req_valid, req_vpn, req_write, resp_ready,
    output req_ready, resp_valid, resp_ppn, resp_fault,
           evict_valid, evict_vpn, evict_dirty
  );

  modport master (
    output req_valid, req_vpn, req_write, resp_ready,
    input  req_ready, resp_valid, resp_ppn, resp_fault,
           evict_valid, evict_vpn, evict_dirty
  );

endinterface

// File: rtl/page_table_walker_clock_hand_replacer.sv
// Frame table and clock hand: exposes the frame under the hand, advances the
// hand on a second-chance skip and claims the frame on allocation.
module clock_hand_replacer
  import vm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance_i,
  input  logic             alloc_i,
  input  logic [VPN_W-1:0] alloc_vpn_i,
  output logic [PPN_W-1:0] hand_o,
  output logic             used_o,
  output logic [VPN_W-1:0] owner_o
);

  frame_t           frames_q [NUM_FRAMES];
  logic [PPN_W-1:0] hand_q;

  // Frame ownership and hand position; the hand wraps naturally at 64.
  always_ff @(posedge clk) begin
    if (rst) begin
      hand_q <= '0;
      for (int unsigned i = 0; i < NUM_FRAMES; i++) frames_q[i] <= '0;
    end else if (alloc_i) begin
      frames_q[hand_q] <= '{used: 1'b1, owner: alloc_vpn_i};
      hand_q           <= hand_q + 1'b1;
    end else if (advance_i) begin
      hand_q <= hand_q + 1'b1;
    end
  end

  assign hand_o  = hand_q;
  assign used_o  = frames_q[hand_q].used;
  assign owner_o = frames_q[hand_q].owner;

endmodule

// File: rtl/page_table_walker.sv
// Page-table walker: translates VPN to PPN from a 256-entry page table, allocates
// frames on faults with clock replacement, and serves reference-bit clears.
// Optional macro STATS_EN adds saturating walk/fault/evict counters.
module page_table_walker
  import vm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_refer,
  page_table_walker_if.slave    bus
`ifdef STATS_EN
  ,
  output logic [CNT_W-1:0]      stat_walks,
  output logic [CNT_W-1:0]      stat_faults,
  output logic [CNT_W-1:0]      stat_evicts
`endif
);

  walk_state_e      state_q, state_d;
  pte_t             pt_q [NUM_PAGES];
  logic [VPN_W-1:0] vpn_q;
  logic             write_q;
  logic [PPN_W-1:0] resp_ppn_q;
  logic             resp_fault_q;
  logic             evict_valid_q, evict_dirty_q;
  logic [VPN_W-1:0] evict_vpn_q;
  logic             clr_prev_q, clr_pend_q;
  logic [VPN_W-1:0] clr_idx_q;

  logic [PPN_W-1:0] hand;
  logic             frame_used;
  logic [VPN_W-1:0] frame_owner;
  logic             advance, alloc, req_fire, go_clear, clr_edge;
  logic             cur_valid, cur_dirty, own_ref, own_dirty;
  logic [PPN_W-1:0] cur_ppn;

  assign cur_valid = pt_q[vpn_q].valid;
  assign cur_dirty = pt_q[vpn_q].dirty;
  assign cur_ppn   = pt_q[vpn_q].ppn;
  assign own_ref   = pt_q[frame_owner].referenced;
  assign own_dirty = pt_q[frame_owner].dirty;
  assign clr_edge  = clear_refer && !clr_prev_q;

  clock_hand_replacer u_replacer (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (advance),
    .alloc_i     (alloc),
    .alloc_vpn_i (vpn_q),
    .hand_o      (hand),
    .used_o      (frame_used),
    .owner_o     (frame_owner)
  );

  // Walk sequencing: a pending clear pre-empts a waiting request in IDLE.
  always_comb begin
    state_d       = state_q;
    advance       = 1'b0;
    alloc         = 1'b0;
    req_fire      = 1'b0;
    go_clear      = 1'b0;
    bus.req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          go_clear = 1'b1;
          state_d  = S_CLEAR;
        end else begin
          bus.req_ready = 1'b1;
          if (bus.req_valid) begin
            req_fire = 1'b1;
            state_d  = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: state_d = cur_valid ? S_UPDATE : S_SCAN_F;
      S_UPDATE: state_d = S_RESP;
      S_SCAN_F: state_d = frame_used ? S_SCAN_P : S_ALLOC;
      S_SCAN_P: begin
        if (own_ref) begin
          advance = 1'b1;
          state_d = S_SCAN_F;
        end else begin
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        alloc   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      S_CLEAR: if (clr_idx_q == '1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, page-table updates and registered response/evict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      vpn_q         <= '0;
      write_q       <= 1'b0;
      resp_ppn_q    <= '0;
      resp_fault_q  <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_dirty_q <= 1'b0;
      evict_vpn_q   <= '0;
      clr_prev_q    <= 1'b0;
      clr_pend_q    <= 1'b0;
      clr_idx_q     <= '0;
      for (int unsigned i = 0; i < NUM_PAGES; i++) pt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      clr_prev_q    <= clear_refer;
      clr_pend_q    <= (clr_pend_q && !go_clear) || clr_edge;
      evict_valid_q <= 1'b0;
      if (req_fire) begin
        vpn_q   <= bus.req_vpn;
        write_q <= bus.req_write;
      end
      case (state_q)
        S_UPDATE: begin
          pt_q[vpn_q].referenced <= 1'b1;
          pt_q[vpn_q].dirty      <= cur_dirty | write_q;
          resp_ppn_q             <= cur_ppn;
          resp_fault_q           <= 1'b0;
        end
        S_SCAN_P: begin
          if (own_ref) begin
            pt_q[frame_owner].referenced <= 1'b0;
          end else begin
            pt_q[frame_owner] <= '0;
            evict_valid_q     <= 1'b1;
            evict_vpn_q       <= frame_owner;
            evict_dirty_q     <= own_dirty;
          end
        end
        S_ALLOC: begin
          pt_q[vpn_q]  <= '{valid: 1'b1, dirty: write_q, referenced: 1'b1, ppn: hand};
          resp_ppn_q   <= hand;
          resp_fault_q <= 1'b1;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_ppn_q   <= '0;
            resp_fault_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          pt_q[clr_idx_q].referenced <= 1'b0;
          clr_idx_q                  <= clr_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_ppn    = resp_ppn_q;
  assign bus.resp_fault  = resp_fault_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_vpn   = evict_vpn_q;
  assign bus.evict_dirty = evict_dirty_q;

`ifdef STATS_EN
  logic [CNT_W-1:0] walks_q, faults_q, evicts_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      walks_q  <= '0;
      faults_q <= '0;
      evicts_q <= '0;
    end else begin
      if (req_fire && walks_q != '1)       walks_q  <= walks_q + 1'b1;
      if (alloc && faults_q != '1)         faults_q <= faults_q + 1'b1;
      if (evict_valid_q && evicts_q != '1) evicts_q <= evicts_q + 1'b1;
    end
  end

  assign stat_walks  = walks_q;
  assign stat_faults = faults_q;
  assign stat_evicts = evicts_q;
`endif

endmodule

// File: tb/tb_page_table_walker.sv
// Scoreboard bench for page_table_walker: directed scenarios then random walks
// against an array-based model of the page table and the clock algorithm.
module tb_page_table_walker;
  import vm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_refer = 1'b0;
  always #5 clk = ~clk;

  page_table_walker_if bus();

`ifdef STATS_EN
  logic [CNT_W-1:0] s_walks, s_faults, s_evicts;
`endif

  page_table_walker dut (
    .clk         (clk),
    .rst         (rst),
    .clear_refer (clear_refer),
    .bus         (bus)
`ifdef STATS_EN
    ,
    .stat_walks  (s_walks),
    .stat_faults (s_faults),
    .stat_evicts (s_evicts)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned hs_cyc   = 0;
  int unsigned last_wait = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] ppn; logic fault; int unsigned lat; } exp_resp_t;
  typedef struct { logic [7:0] vpn; logic dirty; } exp_evict_t;
  exp_resp_t  resp_q[$];
  exp_evict_t evict_q[$];

  // Reference model: page attributes per VPN, frame ownership, clock hand.
  bit         m_valid [256];
  bit         m_dirty [256];
  bit         m_ref   [256];
  logic [5:0] m_ppn   [256];
  bit         f_used  [64];
  logic [7:0] f_owner [64];
  logic [5:0] m_hand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_ref[i] = 0; m_ppn[i] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      f_used[i] = 0; f_owner[i] = '0;
    end
    m_hand = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_ref[i] = 0;
  endtask

  task automatic model_access(input logic [7:0] v, input bit w, output exp_resp_t e);
    logic [7:0] o;
    if (m_valid[v]) begin
      m_ref[v] = 1;
      if (w) m_dirty[v] = 1;
      e.ppn = m_ppn[v]; e.fault = 0; e.lat = 3;
    end else begin
      e.lat = f_used[m_hand] ? 0 : 4;
      while (f_used[m_hand]) begin
        o = f_owner[m_hand];
        if (m_ref[o]) begin
          m_ref[o] = 0;
          m_hand = m_hand + 6'd1;
        end else begin
          evict_q.push_back('{vpn: o, dirty: m_dirty[o]});
          m_valid[o] = 0; m_dirty[o] = 0;
          break;
        end
      end
      m_valid[v] = 1; m_dirty[v] = w; m_ref[v] = 1; m_ppn[v] = m_hand;
      f_used[m_hand] = 1; f_owner[m_hand] = v;
      e.ppn = m_hand; e.fault = 1;
      m_hand = m_hand + 6'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1; bus.req_valid = 0; bus.req_vpn = '0; bus.req_write = 0;
    bus.resp_ready = 1; clear_refer = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    resp_q.delete();
    evict_q.delete();
  endtask

  task automatic do_req(input logic [7:0] v, input bit w, input int unsigned hold);
    exp_resp_t e;
    int unsigned c0, guard;
    bit done;
    @(posedge clk);
    #1;
    if (hold > 0) bus.resp_ready = 0;
    bus.req_valid = 1; bus.req_vpn = v; bus.req_write = w;
    c0 = cyc; done = 0;
    for (guard = 0; guard < 2000 && !done; guard++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        done = 1; hs_cyc = cyc;
        model_access(v, w, e);
        resp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 0;
    check("req_accept", done, 1);
    last_wait = hs_cyc - c0;
    if (hold > 0) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (!bus.resp_valid && guard < 2000);
      repeat (hold) @(posedge clk);
      #1;
      bus.resp_ready = 1;
    end
    guard = 0;
    while (resp_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    check("resp_drain", resp_q.size(), 0);
  endtask

  // Monitor: latency on first presentation, stability under backpressure, data on handshake.
  logic       prev_held = 0;
  logic [5:0] prev_ppn;
  logic       prev_fault;
  always @(negedge clk) begin
    exp_resp_t  er;
    exp_evict_t ev;
    if (rst) begin
      prev_held = 0;
    end else begin
      if (bus.resp_valid) begin
        if (!prev_held) begin
          check("resp_expected", resp_q.size() != 0, 1);
          if (resp_q.size() != 0 && resp_q[0].lat != 0)
            check("resp_latency", cyc - hs_cyc, resp_q[0].lat);
        end else begin
          check("resp_ppn_stable", bus.resp_ppn, prev_ppn);
          check("resp_fault_stable", bus.resp_fault, prev_fault);
        end
        if (!bus.resp_ready) check("req_ready_busy", bus.req_ready, 0);
        if (bus.resp_ready && resp_q.size() != 0) begin
          er = resp_q.pop_front();
          check("resp_ppn", bus.resp_ppn, er.ppn);
          check("resp_fault", bus.resp_fault, er.fault);
        end
      end
      if (bus.evict_valid) begin
        check("evict_expected", evict_q.size() != 0, 1);
        if (evict_q.size() != 0) begin
          ev = evict_q.pop_front();
          check("evict_vpn", bus.evict_vpn, ev.vpn);
          check("evict_dirty", bus.evict_dirty, ev.dirty);
        end
      end
      prev_held  = bus.resp_valid && !bus.resp_ready;
      prev_ppn   = bus.resp_ppn;
      prev_fault = bus.resp_fault;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned guard;
    bit done;

    do_reset();
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_fault", bus.resp_fault, 0);
    check("rst_resp_ppn", bus.resp_ppn, 0);
    check("rst_evict_valid", bus.evict_valid, 0);

    // First fault, then hit on the same page.
    do_req(8'h00, 0, 0);
    do_req(8'h00, 0, 0);
    // Store fault then load hit.
    do_req(8'h05, 1, 0);
    do_req(8'h05, 0, 0);

    // Fill all 64 frames, then force a full second-chance sweep.
    do_reset();
    do_req(8'h00, 1, 0);
    for (int v = 1; v < 64; v++) do_req(8'(v), 0, 0);
    check("evicts_none_yet", evict_q.size(), 0);
    do_req(8'h40, 0, 0);

    // Reference clear pre-empts the next request and takes the full table sweep.
    @(posedge clk);
    #1;
    clear_refer = 1;
    model_clear();
    do_req(8'h41, 0, 0);
    check("clear_wait_cycles", last_wait, 257);
    clear_refer = 0;

    // Backpressure on the response channel.
    do_req(8'h41, 0, 5);

    // Reset while the scan is in SCAN_P drops the walk without an eviction.
    @(posedge clk);
    #1;
    bus.req_valid = 1; bus.req_vpn = 8'h80; bus.req_write = 0;
    done = 0;
    for (guard = 0; guard < 100 && !done; guard++) begin
      @(negedge clk);
      if (bus.req_ready) begin done = 1; hs_cyc = cyc; end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 0;
    check("rst_walk_accept", done, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    resp_q.delete();
    evict_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_req_ready", bus.req_ready, 1);
      check("midrst_resp_valid", bus.resp_valid, 0);
      check("midrst_evict_valid", bus.evict_valid, 0);
    end
    do_req(8'h00, 0, 0);

    // Random traffic with occasional reference clears and backpressure.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(posedge clk);
        #1;
        clear_refer = 1;
        model_clear();
        @(posedge clk);
        #1;
        clear_refer = 0;
      end
      do_req(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    repeat (4) @(negedge clk);
    check("final_resp_queue", resp_q.size(), 0);
    check("final_evict_queue", evict_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
